// File: rtl/rvv_async_rd_arbiter_pkg.sv
// Shared types and defaults for the retire write-back arbiter.
package rvv_async_rd_arbiter_pkg;

    // Number of retire uops the backend can write back per cycle.
    localparam int NUM_RT_UOP  = 4;
    localparam bit DROP_X0_DEF = 1'b1;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

    // One queued scalar write-back at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/rvv_async_rd_arbiter_if.sv
// Write-back channels in, single scalar write port out.
interface rvv_async_rd_arbiter_if
    import rvv_async_rd_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_RT_UOP,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic [NUM_CH-1:0]             wb_valid_i;
    logic [NUM_CH-1:0][ADDR_W-1:0] wb_addr_i;
    logic [NUM_CH-1:0][DATA_W-1:0] wb_data_i;
    logic [NUM_CH-1:0]             wb_ready_o;
    logic                          async_rd_valid;
    logic [ADDR_W-1:0]             async_rd_addr;
    logic [DATA_W-1:0]             async_rd_data;
    logic                          async_rd_ready;

    modport slave (
        input  wb_valid_i, wb_addr_i, wb_data_i, async_rd_ready,
        output wb_ready_o, async_rd_valid, async_rd_addr, async_rd_data
    );

    modport master (
        output wb_valid_i, wb_addr_i, wb_data_i, async_rd_ready,
        input  wb_ready_o, async_rd_valid, async_rd_addr, async_rd_data
    );
endinterface

// File: rtl/rvv_lane_compact.sv
// Prefix count over accepted, non-dropped lanes: gives each kept lane its
// slot offset from the write pointer and the total number of kept lanes.
module rvv_lane_compact
    import rvv_async_rd_arbiter_pkg::*;
#(
    parameter int NUM_CH  = NUM_RT_UOP,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit DROP_X0 = DROP_X0_DEF,
    parameter int CNT_W   = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]             valid_i,
    input  logic [NUM_CH-1:0]             ready_i,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] addr_i,
    output logic [NUM_CH-1:0]             keep_o,
    output logic [NUM_CH-1:0][CNT_W-1:0]  offset_o,
    output logic [CNT_W-1:0]              count_o
);
    logic [CNT_W-1:0] run;

    // Keep accepted lanes unless they target x0 while x0 drop is enabled;
    // each kept lane lands at the running count of kept lanes below it.
    always_comb begin
        run      = '0;
        keep_o   = '0;
        offset_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            keep_o[i]   = valid_i[i] && ready_i[i] && !(DROP_X0 && (addr_i[i] == '0));
            offset_o[i] = run;
            run         = run + CNT_W'(keep_o[i]);
        end
        count_o = run;
    end
endmodule

// File: rtl/rvv_async_rd_arbiter.sv
// Funnels up to NUM_CH write-backs per cycle into a shared circular queue
// drained one entry per cycle to the scalar register file write port.
module rvv_async_rd_arbiter
    import rvv_async_rd_arbiter_pkg::*;
#(
    parameter int NUM_CH  = NUM_RT_UOP,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit DROP_X0 = DROP_X0_DEF,
    localparam int OCC_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    rvv_async_rd_arbiter_if.slave    bus,
    output logic [OCC_W-1:0]         occupancy_o,
    output logic                     idle_o
);
    localparam int SUM_W = PTR_W + CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [NUM_CH-1:0]            keep;
    logic [NUM_CH-1:0][CNT_W-1:0] offset;
    logic [CNT_W-1:0]             enq_cnt;
    logic                         deq;
    entry_t                       head;

    // Pointer add modulo DEPTH; increments never exceed DEPTH, so a single
    // conditional subtract covers non-power-of-two depths.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input logic [CNT_W-1:0] inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + SUM_W'(inc);
        if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
        return PTR_W'(s);
    endfunction

    rvv_lane_compact #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .DROP_X0 (DROP_X0),
        .CNT_W   (CNT_W)
    ) u_compact (
        .valid_i  (bus.wb_valid_i),
        .ready_i  (bus.wb_ready_o),
        .addr_i   (bus.wb_addr_i),
        .keep_o   (keep),
        .offset_o (offset),
        .count_o  (enq_cnt)
    );

    // Free-slot based ready from registered occupancy only, so a slot
    // freed by this cycle's dequeue is offered next cycle.
    always_comb begin
        bus.wb_ready_o = '0;
        for (int i = 0; i < NUM_CH; i++)
            bus.wb_ready_o[i] = (DEPTH - int'(occ_q)) > i;
    end

    // Scatter kept lanes to consecutive slots, wrapping mid-burst.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (keep[i]) begin
                mem_d[wrap_add(wptr_q, offset[i])].addr = bus.wb_addr_i[i];
                mem_d[wrap_add(wptr_q, offset[i])].data = bus.wb_data_i[i];
            end
        end
    end

    // Pointer and occupancy update; empty-queue ready is ignored via deq.
    always_comb begin
        deq    = (occ_q != '0) && bus.async_rd_ready;
        wptr_d = wrap_add(wptr_q, enq_cnt);
        rptr_d = deq ? wrap_add(rptr_q, CNT_W'(1)) : rptr_q;
        occ_d  = occ_q + OCC_W'(enq_cnt) - OCC_W'(deq);
    end

    // Storage carries no reset; stale contents are hidden by the output gate.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Head comes straight from registered storage; zeroed while empty.
    always_comb begin
        head               = mem_q[rptr_q];
        bus.async_rd_valid = (occ_q != '0);
        bus.async_rd_addr  = bus.async_rd_valid ? head.addr : '0;
        bus.async_rd_data  = bus.async_rd_valid ? head.data : '0;
        occupancy_o        = occ_q;
        idle_o             = (occ_q == '0);
    end
endmodule

// File: doc/rvv_async_rd_arbiter.md
RVV_ASYNC_RD_ARBITER -- requirements
Module: rvv_async_rd_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter NUM_CH, default 4: number of retire write-back channels.
REQ-003 Parameter DEPTH, default 8: shared queue entries; DEPTH >= NUM_CH, any integer.
REQ-004 Parameter ADDR_W, default 5, and DATA_W, default 32: scalar register address and data widths.
REQ-005 Parameter DROP_X0, default 1: when 1, writes to address 0 are consumed and discarded.
REQ-006 clk  in  1  clock.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 wb_valid_i  in  NUM_CH  per-channel write-back request, lane 0 oldest.
REQ-009 wb_addr_i  in  NUM_CH x ADDR_W  destination scalar register.
REQ-010 wb_data_i  in  NUM_CH x DATA_W  write-back data.
REQ-011 wb_ready_o  out  NUM_CH  per-channel accept.
REQ-012 async_rd_valid  out  1  head entry valid.
REQ-013 async_rd_addr  out  ADDR_W  head address.
REQ-014 async_rd_data  out  DATA_W  head data.
REQ-015 async_rd_ready  in  1  consumer accept.
REQ-016 occupancy_o  out  clog2(DEPTH+1)  stored entries.
REQ-017 idle_o  out  1  queue empty.

Function
REQ-018 Channel i SHALL be accepted in a cycle when wb_valid_i[i] and wb_ready_o[i] are both high.
REQ-019 wb_ready_o[i] SHALL equal (DEPTH - occupancy_o > i), computed from registered state only, with no dependence on wb_valid_i or async_rd_ready.
REQ-020 Accepted, non-dropped channels SHALL be enqueued compacted in ascending index order at consecutive slots from the write pointer. Gaps from invalid or dropped lanes SHALL consume no slot.
REQ-021 With DROP_X0=1, an accepted lane with address 0 SHALL NOT be enqueued; with DROP_X0=0 it SHALL be enqueued like any other lane.
REQ-022 async_rd_valid SHALL equal (occupancy_o != 0), and async_rd_addr/async_rd_data SHALL present the head entry from registered storage.
REQ-023 Enqueue-to-output latency SHALL be 1 cycle: an entry written in cycle t is visible at the output in cycle t+1 at the earliest, with no combinational bypass.
REQ-024 Dequeue SHALL occur when async_rd_valid and async_rd_ready are both high; the head advances the next cycle.
REQ-025 Output fields SHALL be stable while async_rd_valid is high and async_rd_ready is low.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0, including mid-burst wrap of a multi-lane enqueue.
REQ-027 On simultaneous enqueue of k entries and dequeue, next occupancy SHALL be occupancy + k - 1. A slot freed by a dequeue SHALL become available to wb_ready_o only in the following cycle.
REQ-028 Full queue (occupancy = DEPTH): all wb_ready_o SHALL be low; dequeue proceeds normally.
REQ-029 Empty queue: async_rd_valid SHALL be low, and async_rd_ready SHALL be ignored.
REQ-030 Queue order SHALL equal acceptance order across cycles; no entry is lost, duplicated or reordered.
REQ-031 idle_o SHALL equal (occupancy_o == 0).

Reset
REQ-032 While rstn is low at a clock edge: pointers and occupancy SHALL be 0, async_rd_valid 0, idle_o 1, and wb_ready_o all 1 in the next cycle.
REQ-033 Reset mid-operation SHALL discard all queued entries; storage contents need not be cleared.
REQ-034 async_rd_addr/async_rd_data SHALL be 0 after reset until the first enqueue.

Structure
REQ-035 A shared package SHALL hold the entry typedef {addr, data} and the DROP_X0 default; NUM_CH SHALL default to the backend NUM_RT_UOP constant at instantiation.
REQ-036 The lane compaction (prefix count of valid, non-dropped accepted lanes giving slot offsets) SHALL be one sub-module, rvv_lane_compact. The storage array and pointers SHALL stay in the top module.

Verification
REQ-037 Empty queue, all 4 lanes valid with addr 1,2,3,4, async_rd_ready=1 -> 4 outputs on consecutive cycles starting 1 cycle later, order 1,2,3,4; occupancy 4,3,2,1,0.
REQ-038 DROP_X0=1, lanes valid with addr {5,0,7,0} -> all wb_ready_o high, only 5 then 7 emitted, occupancy reaches 2.
REQ-039 DEPTH=8, occupancy 6, async_rd_ready=0 -> wb_ready_o=4'b0011; lanes 0,1 accepted; then occupancy 8 and wb_ready_o=0.
REQ-040 Write pointer 6, DEPTH=8, 4 lanes enqueued -> entries at slots 6,7,0,1, drained in acceptance order.
REQ-041 Full queue, ready held low 5 cycles -> output fields constant; then ready=1 with lane 0 valid -> dequeue, and lane 0 is accepted only one cycle after the dequeue.
REQ-042 Reset asserted with 3 entries queued -> next cycle async_rd_valid=0, idle_o=1, occupancy 0, wb_ready_o=4'b1111.
